// File: rtl/stepper_profile_gen_if.sv
// Command/status bundle between top-level control and the stepper profile generator.
interface stepper_profile_gen_if #(
  parameter int POS_W = 17,
  parameter int INT_W = 16
);
  logic             start;
  logic [POS_W-1:0] stroke_len;
  logic             auto_rev;
  logic             dir_in;
  logic             stop_req;
  logic             jog;
  logic             step_out;
  logic             dir_out;
  logic             en_n;
  logic             busy;
  logic             done;
  logic [POS_W-1:0] position;
  logic [INT_W-1:0] interval;

  modport master (
    output start, stroke_len, auto_rev, dir_in, stop_req, jog,
    input  step_out, dir_out, en_n, busy, done, position, interval
  );

  modport slave (
    input  start, stroke_len, auto_rev, dir_in, stop_req, jog,
    output step_out, dir_out, en_n, busy, done, position, interval
  );
endinterface

// File: rtl/stepper_profile_gen.sv
// Trapezoidal step/direction generator with ramp-counter based symmetric accel/decel,
// controlled stop, jog mode and optional auto-reverse with dwell.
module stepper_profile_gen #(
  parameter int CLK_DIV        = 270,
  parameter int POS_W          = 17,
  parameter int INT_W          = 16,
  parameter int START_INTERVAL = 1450,
  parameter int MIN_INTERVAL   = 10,
  parameter int JOG_INTERVAL   = 60,
  parameter int PULSE_TICKS    = 2,
  parameter int DWELL_TICKS    = 1023
) (
  input logic                 clk,
  input logic                 rst_n,
  stepper_profile_gen_if.slave bus
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW_W  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS + 1) : 1;
  localparam int CMP_W = (POS_W > INT_W) ? POS_W : INT_W;

  typedef enum logic [1:0] {IDLE, RUN, DWELL, JOG} state_t;

  state_t           state, state_next;
  logic [PRE_W-1:0] pre_cnt;
  logic [INT_W-1:0] pc;
  logic [INT_W-1:0] cur_period;
  logic [INT_W-1:0] rc;
  logic [INT_W-1:0] interval_q;
  logic [POS_W-1:0] position_q;
  logic [POS_W-1:0] stroke_q;
  logic [DW_W-1:0]  dc;
  logic             auto_rev_q;
  logic             dir_q;
  logic             en_n_q;
  logic             step_q;
  logic             done_q;
  logic             stop_flag;
  logic             term_pend;

  logic             tick;
  logic             period_end;
  logic [POS_W-1:0] pos_inc;
  logic [POS_W-1:0] rem;
  logic             end_step;
  logic             ramp_down;
  logic             ramp_up;

  logic launch, jog_enter, restart, dwell_enter, step_edge, finish;

  assign tick       = (pre_cnt == PRE_W'(CLK_DIV - 1));
  assign period_end = tick && (pc == cur_period - INT_W'(1));
  assign pos_inc    = position_q + POS_W'(1);
  assign rem        = stroke_q - pos_inc;
  assign end_step   = (rem == '0) || (stop_flag && (rc == '0));
  assign ramp_down  = (stop_flag || (CMP_W'(rem) <= CMP_W'(rc))) && (rc != '0);
  assign ramp_up    = (interval_q > INT_W'(MIN_INTERVAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A move ending (rule a/b) only marks term_pend; the decision is taken one
  // full period later so the final step keeps its whole period.
  always_comb begin
    state_next  = state;
    launch      = 1'b0;
    jog_enter   = 1'b0;
    restart     = 1'b0;
    dwell_enter = 1'b0;
    step_edge   = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.stroke_len != '0) begin
            state_next = RUN;
            launch     = 1'b1;
          end else begin
            finish = 1'b1;
          end
        end else if (bus.jog) begin
          state_next = JOG;
          jog_enter  = 1'b1;
        end
      end
      RUN: begin
        if (period_end) begin
          if (term_pend) begin
            if (auto_rev_q && !stop_flag) begin
              state_next  = DWELL;
              dwell_enter = 1'b1;
            end else begin
              state_next = IDLE;
              finish     = 1'b1;
            end
          end else begin
            step_edge = 1'b1;
          end
        end
      end
      DWELL: begin
        if (bus.stop_req) begin
          state_next = IDLE;
          finish     = 1'b1;
        end else if (tick && (dc == DW_W'(DWELL_TICKS - 1))) begin
          state_next = RUN;
          restart    = 1'b1;
        end
      end
      JOG: begin
        if (period_end) begin
          if (!bus.jog) begin
            state_next = IDLE;
            finish     = 1'b1;
          end else begin
            step_edge = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // cur_period=1/pc=0 on entry makes the very next tick the first rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt    <= '0;
      pc         <= '0;
      cur_period <= INT_W'(1);
      rc         <= '0;
      interval_q <= INT_W'(START_INTERVAL);
      position_q <= '0;
      stroke_q   <= '0;
      dc         <= '0;
      auto_rev_q <= 1'b0;
      dir_q      <= 1'b0;
      en_n_q     <= 1'b1;
      step_q     <= 1'b0;
      done_q     <= 1'b0;
      stop_flag  <= 1'b0;
      term_pend  <= 1'b0;
    end else begin
      done_q  <= finish;
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);

      if (state == IDLE)
        stop_flag <= 1'b0;
      else if (state == RUN && bus.stop_req)
        stop_flag <= 1'b1;

      if (launch) begin
        stroke_q   <= bus.stroke_len;
        auto_rev_q <= bus.auto_rev;
        dir_q      <= bus.dir_in;
        en_n_q     <= 1'b0;
        position_q <= '0;
        rc         <= '0;
        interval_q <= INT_W'(START_INTERVAL);
        cur_period <= INT_W'(1);
        pc         <= '0;
        term_pend  <= 1'b0;
      end

      if (jog_enter) begin
        dir_q      <= bus.dir_in;
        en_n_q     <= 1'b0;
        position_q <= '0;
        interval_q <= INT_W'(JOG_INTERVAL);
        cur_period <= INT_W'(1);
        pc         <= '0;
      end

      if (restart) begin
        dir_q      <= ~dir_q;
        en_n_q     <= 1'b0;
        position_q <= '0;
        rc         <= '0;
        interval_q <= INT_W'(START_INTERVAL);
        cur_period <= INT_W'(1);
        pc         <= '0;
        term_pend  <= 1'b0;
      end

      if (dwell_enter) begin
        en_n_q <= 1'b1;
        step_q <= 1'b0;
        dc     <= '0;
      end else if (state == DWELL && tick) begin
        dc <= dc + DW_W'(1);
      end

      if (finish) begin
        en_n_q <= 1'b1;
        step_q <= 1'b0;
      end

      // The interval in force when a step rises sets that step's period;
      // the ramp update computed here applies to the following step.
      if (step_edge) begin
        step_q     <= 1'b1;
        pc         <= '0;
        cur_period <= interval_q;
        position_q <= pos_inc;
        if (state == RUN) begin
          if (end_step) begin
            term_pend <= 1'b1;
          end else if (ramp_down) begin
            interval_q <= interval_q + INT_W'(1);
            rc         <= rc - INT_W'(1);
          end else if (ramp_up) begin
            interval_q <= interval_q - INT_W'(1);
            rc         <= rc + INT_W'(1);
          end
        end
      end else if ((state == RUN || state == JOG) && tick) begin
        pc <= pc + INT_W'(1);
        if (pc + INT_W'(1) >= INT_W'(PULSE_TICKS))
          step_q <= 1'b0;
      end
    end
  end

  assign bus.step_out = step_q;
  assign bus.dir_out  = dir_q;
  assign bus.en_n     = en_n_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.position = position_q;
  assign bus.interval = interval_q;

endmodule

// File: tb/tb_stepper_profile_gen.sv
// Scoreboard bench: stimulus queues expected step/done/dwell events, a monitor
// process compares them against the DUT outputs as they appear.
module tb_stepper_profile_gen;

  localparam int CLK_DIV = 2;
  localparam int EV_STEP = 0;
  localparam int EV_DONE = 1;
  localparam int EV_EN   = 2;

  typedef struct {
    int kind;
    int per;
    int dir;
    int pos;
    int gap;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  stepper_profile_gen_if #(.POS_W(17), .INT_W(16)) ifc();

  stepper_profile_gen #(
    .CLK_DIV(CLK_DIV),
    .POS_W(17),
    .INT_W(16),
    .START_INTERVAL(8),
    .MIN_INTERVAL(4),
    .JOG_INTERVAL(3),
    .PULSE_TICKS(1),
    .DWELL_TICKS(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  ptab[$];
  int  checks = 0;
  int  failures = 0;

  int   cyc = 0;
  int   last_rise = 0;
  int   en_rise = 0;
  logic en_rec = 1'b0;
  logic prev_step = 1'b0;
  logic prev_en = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL timeout_%s actual=no_event expected=event", name);
  endtask

  task automatic push(input int kind, input int per, input int dir, input int pos, input int gap);
    ev_t e;
    e.kind = kind; e.per = per; e.dir = dir; e.pos = pos; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Steps 1..n; step k is preceded by period ptab[k-2]; optional done after ptab[n-1].
  task automatic push_stroke(input int n, input int dir, input bit with_done);
    for (int k = 1; k <= n; k++)
      push(EV_STEP, (k == 1) ? -1 : ptab[k-2], dir, k, -1);
    if (with_done)
      push(EV_DONE, ptab[n-1], -1, n, -1);
  endtask

  task automatic observe(input int kind, input int span, input int dir, input int pos, input int gap);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual_kind=%0d expected=none", kind);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    if (e.per >= 0) check("event_period_cycles", span, e.per * CLK_DIV);
    if (e.dir >= 0) check("event_dir", dir, e.dir);
    if (e.pos >= 0) check("event_position", pos, e.pos);
    if (e.gap >= 0) check("event_gap_cycles", gap, e.gap * CLK_DIV);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_step = 1'b0;
        prev_en   = 1'b1;
        en_rec    = 1'b0;
      end else begin
        if (ifc.step_out && !prev_step) begin
          observe(EV_STEP, cyc - last_rise, int'(ifc.dir_out), int'(ifc.position), -1);
          last_rise = cyc;
        end
        if (ifc.done)
          observe(EV_DONE, cyc - last_rise, 0, int'(ifc.position), -1);
        if (ifc.en_n && !prev_en && ifc.busy) begin
          en_rise = cyc;
          en_rec  = 1'b1;
        end else if (!ifc.en_n && prev_en && en_rec) begin
          observe(EV_EN, cyc - en_rise, 0, 0, en_rise - last_rise);
          en_rec = 1'b0;
        end
        if (!ifc.busy) en_rec = 1'b0;
        prev_step = ifc.step_out;
        prev_en   = ifc.en_n;
      end
    end
  end

  task automatic wait_pos(input int n, input string name);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (int'(ifc.position) == n) break;
    end
    if (i == 2000) timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!ifc.busy) break;
    end
    if (i == 4000) timeout(name);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_dwell(input int count, input string name);
    int   i;
    int   seen;
    logic pe;
    seen = 0;
    pe   = ifc.en_n;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (ifc.en_n && !pe && ifc.busy) seen++;
      pe = ifc.en_n;
      if (seen == count) break;
    end
    if (i == 4000) timeout(name);
  endtask

  task automatic pulse_start(input int len, input bit rev, input bit dir);
    ifc.stroke_len = 17'(len);
    ifc.auto_rev   = rev;
    ifc.dir_in     = dir;
    ifc.start      = 1'b1;
    @(negedge clk);
    ifc.start      = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_step_out"}, int'(ifc.step_out), 0);
    check({tag, "_dir_out"},  int'(ifc.dir_out), 0);
    check({tag, "_en_n"},     int'(ifc.en_n), 1);
    check({tag, "_busy"},     int'(ifc.busy), 0);
    check({tag, "_done"},     int'(ifc.done), 0);
    check({tag, "_position"}, int'(ifc.position), 0);
    check({tag, "_interval"}, int'(ifc.interval), 8);
  endtask

  initial begin : stimulus
    ifc.start = 1'b0; ifc.stroke_len = '0; ifc.auto_rev = 1'b0;
    ifc.dir_in = 1'b0; ifc.stop_req = 1'b0; ifc.jog = 1'b0;
    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Full trapezoid
    ptab = {8,7,6,5,4,4,4,4,4,4,4,4,4,4,4,4,5,6,7,8};
    push_stroke(20, 0, 1'b1);
    pulse_start(20, 1'b0, 1'b0);
    wait_idle("trapezoid");
    check("trap_busy", int'(ifc.busy), 0);
    check("trap_en_n", int'(ifc.en_n), 1);
    check("trap_position", int'(ifc.position), 20);

    // Triangular profile
    ptab = {8,7,6,5,6,7};
    push_stroke(6, 1, 1'b1);
    pulse_start(6, 1'b0, 1'b1);
    wait_idle("triangle");
    check("tri_position", int'(ifc.position), 6);

    // Controlled stop after the third rising edge
    ptab = {8,7,6,5,6,7,8};
    push_stroke(7, 0, 1'b1);
    pulse_start(100, 1'b0, 1'b0);
    wait_pos(3, "stop_third_edge");
    ifc.stop_req = 1'b1;
    @(negedge clk);
    ifc.stop_req = 1'b0;
    wait_idle("stop");
    check("stop_position", int'(ifc.position), 7);

    // Auto-reverse with dwell, stopped during the third dwell
    ptab = {8,7,6,7};
    push_stroke(4, 0, 1'b0);
    push(EV_EN, 5, -1, -1, 7);
    push_stroke(4, 1, 1'b0);
    push(EV_EN, 5, -1, -1, 7);
    push_stroke(4, 0, 1'b0);
    push(EV_DONE, -1, -1, 4, -1);
    pulse_start(4, 1'b1, 1'b0);
    wait_dwell(3, "third_dwell");
    @(negedge clk);
    ifc.stop_req = 1'b1;
    @(negedge clk);
    ifc.stop_req = 1'b0;
    wait_idle("auto_rev");
    check("rev_en_n", int'(ifc.en_n), 1);

    // Jog for ten steps, start ignored, drop mid-period
    push(EV_STEP, -1, 1, 1, -1);
    for (int k = 2; k <= 10; k++) push(EV_STEP, 3, 1, k, -1);
    push(EV_DONE, 3, -1, 10, -1);
    ifc.dir_in = 1'b1;
    ifc.jog    = 1'b1;
    wait_pos(10, "jog_tenth");
    @(negedge clk);
    pulse_start(5, 1'b0, 1'b1);
    ifc.jog = 1'b0;
    wait_idle("jog");
    check("jog_interval", int'(ifc.interval), 3);

    // Asynchronous reset in the middle of a move
    ptab = {8,7};
    push(EV_STEP, -1, 1, 1, -1);
    push(EV_STEP, 8, 1, 2, -1);
    push(EV_STEP, 7, 1, 3, -1);
    pulse_start(20, 1'b0, 1'b1);
    wait_pos(3, "reset_third_edge");
    check("pre_reset_step_out", int'(ifc.step_out), 1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_busy", int'(ifc.busy), 0);

    // Zero-length stroke: done only
    push(EV_DONE, -1, -1, 0, -1);
    pulse_start(0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("zero_len_busy", int'(ifc.busy), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
